boot_wb_loader: RTL and testbench

- Program-image loader and CPU reset sequencer between the testbench clock/reset generator and orpsoc_top.
- While the CPU is held in reset, it accepts 32-bit image words from a valid/ready source and writes them through a Wishbone B3 classic master port into system RAM.
- Once loading finishes it releases cpu_rst_o after a programmable hold time.
- Replaces backdoor ELF loading, so the RAM preload is visible on the bus.

---
 rtl/boot_wb_loader.sv | 137 +++++++++++++
 tb/tb_boot_wb_loader.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_wb_loader.sv
// boot_wb_loader: streams a boot image into RAM over a Wishbone B3 classic master
// while holding the CPU in reset, then releases the reset after a programmable hold.
module boot_wb_loader #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] MAX_WORDS   = 32'h0080_0000,
    parameter int unsigned RST_HOLD    = 16,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rstn_i,
    input  logic        src_valid_i,
    input  logic [31:0] src_data_i,
    input  logic        src_last_i,
    input  logic        src_skip_i,
    output logic        src_ready_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic        cpu_rst_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] word_cnt_o
);
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, HOLD, RUN, ERROR} state_t;

    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] adr_q, adr_d, dat_q, dat_d, cnt_q, cnt_d, hold_q, hold_d;
    logic [3:0]  sel_q, sel_d;
    logic [7:0]  tmo_q, tmo_d;
    logic        cyc_q, cyc_d, last_q, last_d, rst_q, rst_d, done_q, done_d, err_q, err_d;

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        tmo_d   = tmo_q;
        cyc_d   = cyc_q;
        last_d  = last_q;
        rst_d   = rst_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            IDLE: state_d = LOAD;
            LOAD: begin
                if (src_valid_i) begin
                    adr_d   = BASE_ADDR + {cnt_q[29:0], 2'b00};
                    dat_d   = src_data_i;
                    sel_d   = 4'hF;
                    cyc_d   = 1'b1;
                    last_d  = src_last_i;
                    tmo_d   = '0;
                    state_d = WRITE;
                end else if (src_skip_i) begin
                    hold_d  = 32'(RST_HOLD);
                    state_d = HOLD;
                end
            end
            WRITE: begin
                // a bus error beats a simultaneous ack; timeout only fires with neither present
                if (wbm_err_i || (!wbm_ack_i && tmo_q == TMO_LAST)) begin
                    cyc_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ERROR;
                end else if (wbm_ack_i) begin
                    cyc_d   = 1'b0;
                    cnt_d   = cnt_q + 32'd1;
                    hold_d  = 32'(RST_HOLD);
                    state_d = (last_q || cnt_d == MAX_WORDS) ? HOLD : LOAD;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            HOLD: begin
                if (hold_q == '0) begin
                    rst_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    hold_d = hold_q - 32'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q <= IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            hold_q  <= '0;
            tmo_q   <= '0;
            cyc_q   <= 1'b0;
            last_q  <= 1'b0;
            rst_q   <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            tmo_q   <= tmo_d;
            cyc_q   <= cyc_d;
            last_q  <= last_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign src_ready_o = (state_q == LOAD);
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_we_o    = cyc_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign cpu_rst_o   = rst_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign word_cnt_o  = cnt_q;
endmodule

// File: tb/tb_boot_wb_loader.sv
// tb_boot_wb_loader: vector table, hand sequences and randomized image loads
// checked against a transaction-level model of the loader.
module tb_boot_wb_loader;
    localparam int MAXW = 4;
    localparam int TMO  = 255;

    logic clk = 0, rstn = 1;
    always #5 clk = ~clk;

    logic        src_valid = 0, src_last = 0, src_skip = 0, ack = 0, werr = 0;
    logic [31:0] src_data = 0;
    logic        a_ready, a_we, a_cyc, a_stb, a_rst, a_done, a_err;
    logic [31:0] a_adr, a_dat, a_cnt;
    logic [3:0]  a_sel;
    logic        b_ready, b_we, b_cyc, b_stb, b_rst, b_done, b_err;
    logic [31:0] b_adr, b_dat, b_cnt;
    logic [3:0]  b_sel;

    boot_wb_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(32'(MAXW)), .RST_HOLD(16), .ACK_TIMEOUT(TMO)) u_a (
        .wb_clk_i(clk), .wb_rstn_i(rstn), .src_valid_i(src_valid), .src_data_i(src_data),
        .src_last_i(src_last), .src_skip_i(src_skip), .src_ready_o(a_ready),
        .wbm_adr_o(a_adr), .wbm_dat_o(a_dat), .wbm_sel_o(a_sel), .wbm_we_o(a_we),
        .wbm_cyc_o(a_cyc), .wbm_stb_o(a_stb), .wbm_ack_i(ack), .wbm_err_i(werr),
        .cpu_rst_o(a_rst), .done_o(a_done), .err_o(a_err), .word_cnt_o(a_cnt));

    boot_wb_loader #(.RST_HOLD(0)) u_b (
        .wb_clk_i(clk), .wb_rstn_i(rstn), .src_valid_i(src_valid), .src_data_i(src_data),
        .src_last_i(src_last), .src_skip_i(src_skip), .src_ready_o(b_ready),
        .wbm_adr_o(b_adr), .wbm_dat_o(b_dat), .wbm_sel_o(b_sel), .wbm_we_o(b_we),
        .wbm_cyc_o(b_cyc), .wbm_stb_o(b_stb), .wbm_ack_i(ack), .wbm_err_i(werr),
        .cpu_rst_o(b_rst), .done_o(b_done), .err_o(b_err), .word_cnt_o(b_cnt));

    int errors = 0, checks = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // source: words handed over on valid & ready
    logic [31:0] sq_d[$];
    bit          sq_l[$];
    bit          consume = 0, gaps = 0;
    int          taken = 0;
    always @(negedge clk) begin
        if (consume) begin
            sq_d.delete(0);
            sq_l.delete(0);
            taken++;
        end
        src_valid = sq_d.size() > 0 && !(gaps && $urandom_range(0, 2) == 0);
        src_data  = sq_d.size() > 0 ? sq_d[0] : 32'h0;
        src_last  = sq_d.size() > 0 ? sq_l[0] : 1'b0;
        consume   = src_valid && a_ready && rstn;
    end

    // slave: per-write wait states and error flags
    int s_dly[16];
    bit s_er[16], s_both[16];
    int s_idx = 0, s_wait = 0;
    always @(negedge clk) begin
        ack = 0;
        werr = 0;
        if (!rstn || !a_cyc) s_wait = 0;
        else if (s_idx < 16 && s_wait == s_dly[s_idx]) begin
            werr = s_er[s_idx];
            ack = !s_er[s_idx] || s_both[s_idx];
            s_idx++;
            s_wait = 0;
        end else s_wait++;
    end

    typedef struct {logic [31:0] adr, dat; logic [3:0] sel; logic we, er;} wr_t;
    wr_t  obs[$];
    int   cyc_n = 0, last_ack = 0, fall_at = 0, cyc_hi = 0;
    bit   b_cyc_seen = 0, ready_late = 0;
    logic prev_rst = 1;
    always @(posedge clk) begin
        cyc_n++;
        if (rstn && a_cyc && a_stb && (ack || werr)) begin
            obs.push_back('{a_adr, a_dat, a_sel, a_we, werr});
            last_ack = cyc_n;
        end
    end
    always @(negedge clk) begin
        if (a_cyc) cyc_hi++;
        if (b_cyc) b_cyc_seen = 1;
        if ((a_done || a_err) && a_ready) ready_late = 1;
        if (prev_rst && !a_rst) fall_at = cyc_n;
        prev_rst = a_rst;
    end

    // transaction-level reference
    logic [31:0] m_d[$], ex_adr[$], ex_dat[$];
    bit          m_l[$], ex_er[$];
    int          exp_cnt, exp_err, exp_done;

    task automatic model();
        ex_adr.delete(); ex_dat.delete(); ex_er.delete();
        exp_cnt = 0; exp_err = 0; exp_done = 0;
        for (int i = 0; i < m_d.size(); i++) begin
            if (s_dly[i] < TMO) begin
                ex_adr.push_back(32'(4 * i));
                ex_dat.push_back(m_d[i]);
                ex_er.push_back(s_er[i]);
            end
            if (s_er[i] || s_dly[i] >= TMO) begin
                exp_err = 1;
                break;
            end
            exp_cnt++;
            if (m_l[i] || exp_cnt == MAXW) begin
                exp_done = 1;
                break;
            end
        end
    endtask

    task automatic compare_model(input string nm);
        check({nm, " nwrites"}, obs.size(), ex_adr.size());
        for (int i = 0; i < obs.size() && i < ex_adr.size(); i++) begin
            check($sformatf("%s adr%0d", nm, i), obs[i].adr, ex_adr[i]);
            check($sformatf("%s dat%0d", nm, i), obs[i].dat, ex_dat[i]);
            check($sformatf("%s sel%0d", nm, i), obs[i].sel, 4'hF);
            check($sformatf("%s we%0d", nm, i), obs[i].we, 1);
            check($sformatf("%s er%0d", nm, i), obs[i].er, ex_er[i]);
        end
        check({nm, " cnt"}, a_cnt, exp_cnt);
        check({nm, " err"}, a_err, exp_err);
        check({nm, " done"}, a_done, exp_done);
        check({nm, " cpu_rst"}, a_rst, !exp_done);
        check({nm, " taken"}, taken, exp_cnt + exp_err);
        check({nm, " ready_after_end"}, ready_late, 0);
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rstn = 0;
        sq_d.delete(); sq_l.delete();
        consume = 0; taken = 0; s_idx = 0; obs.delete();
        cyc_hi = 0; b_cyc_seen = 0; ready_late = 0; src_skip = 0; gaps = 0;
        @(negedge clk); #1;
        rstn = 1;
    endtask

    task automatic set_resp(input int dly, input int err_at, input bit both);
        for (int i = 0; i < 16; i++) begin
            s_dly[i] = dly;
            s_er[i] = (i == err_at);
            s_both[i] = both;
        end
    endtask

    task automatic push_word(input logic [31:0] d, input bit l);
        sq_d.push_back(d);
        sq_l.push_back(l);
        m_d.push_back(d);
        m_l.push_back(l);
    endtask

    task automatic wait_end(input int maxc, input string nm);
        int n = 0;
        while (!(a_done || a_err) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check({nm, " finished"}, a_done || a_err, 1);
        repeat (3) @(negedge clk);
    endtask

    typedef struct {int nw; int last_at; int err_at; bit both; int dly; int cnt; bit er; bit dn;} vec_t;
    vec_t tbl[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{3, 2, -1, 0, 0, 3, 0, 1};
        tbl[1] = '{3, 2, 1, 0, 1, 1, 1, 0};
        tbl[2] = '{3, 2, 1, 1, 0, 1, 1, 0};
        tbl[3] = '{6, -1, -1, 0, 0, 4, 0, 1};
        tbl[4] = '{1, 0, 0, 0, 2, 0, 1, 0};
        tbl[5] = '{5, 4, -1, 0, 2, 4, 0, 1};

        // asynchronous reset, before any clock edge
        #2 rstn = 0;
        #1;
        check("rst ready", a_ready, 0);
        check("rst cyc", a_cyc, 0);
        check("rst stb", a_stb, 0);
        check("rst we", a_we, 0);
        check("rst adr", a_adr, 0);
        check("rst dat", a_dat, 0);
        check("rst sel", a_sel, 0);
        check("rst cpu_rst", a_rst, 1);
        check("rst done", a_done, 0);
        check("rst err", a_err, 0);
        check("rst cnt", a_cnt, 0);

        // three words, zero-wait ack, reset release timing
        do_reset();
        set_resp(0, -1, 0);
        m_d.delete(); m_l.delete();
        push_word(32'h11111111, 0);
        push_word(32'h22222222, 0);
        push_word(32'h33333333, 1);
        model();
        wait_end(200, "three");
        compare_model("three");
        check("three adr2", obs.size() > 2 ? obs[2].adr : 32'hx, 32'h8);
        check("three rst_fall_delay", fall_at - last_ack, 17);

        // skip with zero hold on the second instance
        do_reset();
        src_skip = 1;
        repeat (3) @(posedge clk);
        #1;
        check("skip cpu_rst", b_rst, 0);
        check("skip done", b_done, 1);
        check("skip cnt", b_cnt, 0);
        check("skip no_bus", b_cyc_seen, 0);

        // slave never answers
        do_reset();
        set_resp(1000, -1, 0);
        m_d.delete(); m_l.delete();
        push_word(32'hDEADBEEF, 1);
        model();
        wait_end(600, "tmo");
        compare_model("tmo");
        check("tmo cyc_cycles", cyc_hi, 255);

        // ack on the 254th wait cycle completes normally
        do_reset();
        set_resp(253, -1, 0);
        m_d.delete(); m_l.delete();
        push_word(32'hCAFEF00D, 1);
        model();
        wait_end(600, "ack254");
        compare_model("ack254");
        check("ack254 cyc_cycles", cyc_hi, 254);

        // asynchronous reset during the second write
        do_reset();
        set_resp(0, -1, 0);
        s_dly[1] = 1000;
        push_word(32'h1, 0);
        push_word(32'h2, 0);
        push_word(32'h3, 1);
        begin
            int n = 0;
            while (!(obs.size() == 1 && a_cyc) && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("midrst reached write2", obs.size() == 1 && a_cyc, 1);
        end
        #3 rstn = 0;
        #1;
        check("midrst cyc", a_cyc, 0);
        check("midrst stb", a_stb, 0);
        check("midrst cnt", a_cnt, 0);
        check("midrst cpu_rst", a_rst, 1);
        do_reset();
        set_resp(0, -1, 0);
        m_d.delete(); m_l.delete();
        push_word(32'hA5A5A5A5, 0);
        push_word(32'h5A5A5A5A, 1);
        model();
        wait_end(200, "reload");
        compare_model("reload");

        // vector table
        for (int t = 0; t < 6; t++) begin
            string nm;
            nm = $sformatf("vec%0d", t);
            do_reset();
            set_resp(tbl[t].dly, tbl[t].err_at, tbl[t].both);
            m_d.delete(); m_l.delete();
            for (int i = 0; i < tbl[t].nw; i++) push_word(32'hA0000000 + 32'(i * 257), i == tbl[t].last_at);
            model();
            wait_end(500, nm);
            compare_model(nm);
            check({nm, " tbl_cnt"}, a_cnt, tbl[t].cnt);
            check({nm, " tbl_err"}, a_err, tbl[t].er);
            check({nm, " tbl_done"}, a_done, tbl[t].dn);
        end

        // randomized loads
        for (int r = 0; r < 20; r++) begin
            int nw;
            do_reset();
            gaps = 1;
            set_resp(0, -1, 0);
            m_d.delete(); m_l.delete();
            nw = $urandom_range(1, 6);
            for (int i = 0; i < nw; i++) begin
                s_dly[i] = $urandom_range(0, 3);
                s_er[i] = ($urandom_range(0, 9) == 0);
                s_both[i] = $urandom_range(0, 1) == 1;
                push_word($urandom, (i == nw - 1) && (nw <= MAXW || $urandom_range(0, 1) == 1));
            end
            model();
            wait_end(500, $sformatf("rand%0d", r));
            compare_model($sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
